evg_event_arbiter: RTL and testbench

Merges all event-code requests of the event generator into the single stream handed to the event transmitter. Sits directly downstream of the two sequence generators, whose event outputs cannot be stalled. Also accepts hardware trigger inputs and a software event request. Buffers sequencer events in per-source FIFOs, arbitrates by fixed priority, and presents one registered valid/ready stream to the transmitter, running entirely in the transmitter clock domain.

---
 rtl/evg_event_pkg.sv | 26 ++
 rtl/evg_event_arbiter_if.sv | 13 +
 rtl/evg_event_fifo.sv | 50 +++++
 rtl/evg_event_arbiter.sv | 148 ++++++++++++++
 tb/tb_evg_event_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/evg_event_pkg.sv
// Shared types and helpers for the event generator merge path.
// Code widths, reserved codes, source/state enums and the debug struct.
package evg_event_pkg;

    localparam int EVENTCODE_WIDTH_DEFAULT = 8;
    localparam int NULL_EVENT_CODE = 0;
    localparam logic [7:0] END_OF_TABLE_EVENT_CODE = 8'h7F;

    typedef enum logic [1:0] {TRIG, SEQA, SEQB, SW} src_sel_e;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

    // Observation struct: output register state, last loaded source, FIFO full flags, pending triggers.
    typedef struct packed {
        out_state_e outState;
        src_sel_e   lastSrc;
        logic       seqAFull;
        logic       seqBFull;
        logic [7:0] pending;
    } evg_dbg_t;

    function automatic logic [7:0] satInc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/evg_event_arbiter_if.sv
// Event code stream bundle, used for both the software request and the transmitter output.
// Handshake: a beat transfers on a rising clock edge where TVALID and TREADY are both 1;
// the master holds TDATA stable while TVALID=1 and TREADY=0.
interface evg_event_arbiter_if #(
    parameter int EVENTCODE_WIDTH = evg_event_pkg::EVENTCODE_WIDTH_DEFAULT
);
    logic [EVENTCODE_WIDTH-1:0] TDATA;
    logic                       TVALID;
    logic                       TREADY;

    modport master (output TDATA, output TVALID, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/evg_event_fifo.sv
// Synchronous FIFO for one sequencer. Pointers carry an extra wrap bit so full and empty
// are distinguishable; a push into a full FIFO succeeds only if a pop happens in the same cycle.
module evg_event_fifo
    import evg_event_pkg::*;
#(
    parameter int WIDTH = EVENTCODE_WIDTH_DEFAULT,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       popData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
    assign doPop    = pop && !empty;
    assign doPush   = push && (!full || doPop);
    assign overflow = push && !doPush;
    assign popData  = mem[rdPtr[AW-1:0]];
    assign fill     = wrPtr - rdPtr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/evg_event_arbiter.sv
// Merges trigger, sequencer and software event codes into one registered stream for the
// transmitter: per-sequencer FIFOs, fixed-priority load, trigger edge/pending logic, statistics.
module evg_event_arbiter
    import evg_event_pkg::*;
#(
    parameter int EVENTCODE_WIDTH = EVENTCODE_WIDTH_DEFAULT,
    parameter int SEQ_FIFO_DEPTH  = 16,
    parameter int NUM_TRIGGERS    = 4
) (
    input  logic                                    evgTxClk,
    input  logic                                    evgTxRst_n,
    input  logic [EVENTCODE_WIDTH-1:0]              seqATDATA,
    input  logic                                    seqATVALID,
    input  logic [EVENTCODE_WIDTH-1:0]              seqBTDATA,
    input  logic                                    seqBTVALID,
    evg_event_arbiter_if.slave                      sw,
    input  logic [NUM_TRIGGERS-1:0]                 trigIn,
    input  logic [NUM_TRIGGERS*EVENTCODE_WIDTH-1:0] trigCodes,
    input  logic                                    statsClear,
    evg_event_arbiter_if.master                     evgTxEvent,
    output logic [7:0]                              seqAOverflowCount,
    output logic [7:0]                              seqBOverflowCount,
    output logic [7:0]                              trigCoalesceCount,
    output logic [$clog2(SEQ_FIFO_DEPTH):0]         seqAFill,
    output logic [$clog2(SEQ_FIFO_DEPTH):0]         seqBFill,
    output evg_dbg_t                                dbg
);
    localparam logic [EVENTCODE_WIDTH-1:0] NULL_CODE = EVENTCODE_WIDTH'(NULL_EVENT_CODE);

    out_state_e                 outState;
    src_sel_e                   lastSrc;
    logic [NUM_TRIGGERS-1:0]    trigPrev, pending, trigEdge, trigSel, trigClear, coalesce;
    logic [EVENTCODE_WIDTH-1:0] trigCode, aData, bData, loadCode;
    logic                       aEmpty, bEmpty, aFull, bFull, aOvf, bOvf, popA, popB;
    logic                       loadSlot, loadEn, swAck;
    src_sel_e                   loadSrc;
    logic [7:0]                 coalNext;

    evg_event_fifo #(.WIDTH(EVENTCODE_WIDTH), .DEPTH(SEQ_FIFO_DEPTH)) fifoA (
        .clk(evgTxClk), .rst_n(evgTxRst_n),
        .push(seqATVALID && (seqATDATA != NULL_CODE)), .pushData(seqATDATA),
        .pop(popA), .popData(aData), .full(aFull), .empty(aEmpty),
        .fill(seqAFill), .overflow(aOvf)
    );

    evg_event_fifo #(.WIDTH(EVENTCODE_WIDTH), .DEPTH(SEQ_FIFO_DEPTH)) fifoB (
        .clk(evgTxClk), .rst_n(evgTxRst_n),
        .push(seqBTVALID && (seqBTDATA != NULL_CODE)), .pushData(seqBTDATA),
        .pop(popB), .popData(bData), .full(bFull), .empty(bEmpty),
        .fill(seqBFill), .overflow(bOvf)
    );

    assign trigEdge = trigIn & ~trigPrev;
    // An edge landing on the cycle its pending bit is consumed re-arms it without counting.
    assign coalesce = trigEdge & pending & ~trigClear;

    always_comb begin
        trigSel  = '0;
        trigCode = NULL_CODE;
        for (int i = NUM_TRIGGERS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                trigSel    = '0;
                trigSel[i] = 1'b1;
                trigCode   = trigCodes[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH];
            end
        end
    end

    always_comb begin
        loadSlot  = (outState == OUT_EMPTY) || evgTxEvent.TREADY;
        loadEn    = 1'b0;
        loadCode  = NULL_CODE;
        loadSrc   = SW;
        popA      = 1'b0;
        popB      = 1'b0;
        swAck     = 1'b0;
        trigClear = '0;
        if (|pending) begin
            loadEn    = loadSlot;
            loadCode  = trigCode;
            loadSrc   = TRIG;
            trigClear = loadSlot ? trigSel : '0;
        end else if (!aEmpty) begin
            loadEn   = loadSlot;
            loadCode = aData;
            loadSrc  = SEQA;
            popA     = loadSlot;
        end else if (!bEmpty) begin
            loadEn   = loadSlot;
            loadCode = bData;
            loadSrc  = SEQB;
            popB     = loadSlot;
        end else if (sw.TVALID) begin
            // A null software code is acknowledged but never reaches the output register.
            swAck    = loadSlot;
            loadEn   = loadSlot && (sw.TDATA != NULL_CODE);
            loadCode = sw.TDATA;
            loadSrc  = SW;
        end
    end

    always_comb begin
        coalNext = statsClear ? 8'd0 : trigCoalesceCount;
        for (int i = 0; i < NUM_TRIGGERS; i++) begin
            if (coalesce[i]) coalNext = satInc(coalNext);
        end
    end

    assign sw.TREADY         = swAck;
    assign evgTxEvent.TVALID = (outState == OUT_FULL);

    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            outState          <= OUT_EMPTY;
            lastSrc           <= TRIG;
            evgTxEvent.TDATA  <= '0;
            trigPrev          <= '0;
            pending           <= '0;
            seqAOverflowCount <= '0;
            seqBOverflowCount <= '0;
            trigCoalesceCount <= '0;
        end else begin
            trigPrev <= trigIn;
            pending  <= (pending & ~trigClear) | trigEdge;
            if (loadSlot) begin
                if (loadEn) begin
                    outState         <= OUT_FULL;
                    evgTxEvent.TDATA <= loadCode;
                    lastSrc          <= loadSrc;
                end else begin
                    outState <= OUT_EMPTY;
                end
            end
            if (statsClear)  seqAOverflowCount <= aOvf ? 8'd1 : 8'd0;
            else if (aOvf)   seqAOverflowCount <= satInc(seqAOverflowCount);
            if (statsClear)  seqBOverflowCount <= bOvf ? 8'd1 : 8'd0;
            else if (bOvf)   seqBOverflowCount <= satInc(seqBOverflowCount);
            trigCoalesceCount <= coalNext;
        end
    end

    assign dbg.outState = outState;
    assign dbg.lastSrc  = lastSrc;
    assign dbg.seqAFull = aFull;
    assign dbg.seqBFull = bFull;
    assign dbg.pending  = 8'(pending);

endmodule

// File: tb/tb_evg_event_arbiter.sv
// Bench for evg_event_arbiter: scenario tasks with inline checks and an expected-beat queue
// popped whenever the transmitter side accepts a beat.
module tb_evg_event_arbiter;
    import evg_event_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] seq_a_data = '0, seq_b_data = '0;
    logic       seq_a_valid = 1'b0, seq_b_valid = 1'b0;
    logic [3:0] trig_in = '0;
    logic [31:0] trig_codes = {8'h33, 8'h30, 8'h32, 8'h31};
    logic       stats_clear = 1'b0;
    logic [7:0] seq_a_ovf, seq_b_ovf, trig_coal;
    logic [4:0] seq_a_fill, seq_b_fill;
    evg_dbg_t   dbg;

    evg_event_arbiter_if #(.EVENTCODE_WIDTH(8)) swIf ();
    evg_event_arbiter_if #(.EVENTCODE_WIDTH(8)) txIf ();

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    evg_event_arbiter #(.EVENTCODE_WIDTH(8), .SEQ_FIFO_DEPTH(16), .NUM_TRIGGERS(4)) dut (
        .evgTxClk(clk), .evgTxRst_n(rst_n),
        .seqATDATA(seq_a_data), .seqATVALID(seq_a_valid),
        .seqBTDATA(seq_b_data), .seqBTVALID(seq_b_valid),
        .sw(swIf), .trigIn(trig_in), .trigCodes(trig_codes), .statsClear(stats_clear),
        .evgTxEvent(txIf),
        .seqAOverflowCount(seq_a_ovf), .seqBOverflowCount(seq_b_ovf),
        .trigCoalesceCount(trig_coal), .seqAFill(seq_a_fill), .seqBFill(seq_b_fill),
        .dbg(dbg)
    );

    // Scoreboard: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && txIf.TVALID && txIf.TREADY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected got=%h want=none", txIf.TDATA);
            end else begin
                mon_exp = exp_q.pop_front();
                if (txIf.TDATA !== mon_exp) begin
                    errors++;
                    $display("FAIL beat_order got=%h want=%h", txIf.TDATA, mon_exp);
                end
            end
        end
    end

    task automatic occupy_output(input logic [7:0] code, input bit track);
        @(posedge clk); #1;
        seq_b_data = code;
        seq_b_valid = 1'b1;
        if (track) exp_q.push_back(code);
        @(posedge clk); #1;
        seq_b_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        swIf.TDATA = '0;
        swIf.TVALID = 1'b0;
        txIf.TREADY = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (txIf.TVALID !== 1'b0 || txIf.TDATA !== 8'h00 || swIf.TREADY !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%h/%b want=0/00/0", txIf.TVALID, txIf.TDATA, swIf.TREADY);
        end
        checks++;
        if (seq_a_ovf !== 8'd0 || seq_b_ovf !== 8'd0 || trig_coal !== 8'd0 ||
            seq_a_fill !== 5'd0 || seq_b_fill !== 5'd0 || dbg.pending !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters got=%h %h %h %h %h %h want=0", seq_a_ovf, seq_b_ovf,
                     trig_coal, seq_a_fill, seq_b_fill, dbg.pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        txIf.TREADY = 1'b1;
        @(posedge clk); #1;
        seq_a_data = 8'h21;
        seq_a_valid = 1'b1;
        exp_q.push_back(8'h21);
        @(posedge clk); #1;
        seq_a_valid = 1'b0;
        checks++;
        if (txIf.TVALID !== 1'b0) begin
            errors++;
            $display("FAIL single_early got=%b want=0", txIf.TVALID);
        end
        @(posedge clk); #1;
        checks++;
        if (txIf.TVALID !== 1'b1 || txIf.TDATA !== 8'h21) begin
            errors++;
            $display("FAIL single_latency got=%b/%h want=1/21", txIf.TVALID, txIf.TDATA);
        end
        @(posedge clk); #1;
        checks++;
        if (txIf.TVALID !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle got=%b want=0", txIf.TVALID);
        end
    endtask

    task automatic test_overflow;
        txIf.TREADY = 1'b0;
        occupy_output(8'h13, 1'b1);
        for (int i = 0; i < 20; i++) begin
            seq_a_data = 8'(8'h50 + i);
            seq_a_valid = 1'b1;
            if (i < 16) exp_q.push_back(8'(8'h50 + i));
            @(posedge clk); #1;
        end
        seq_a_valid = 1'b0;
        checks++;
        if (seq_a_fill !== 5'd16 || seq_a_ovf !== 8'd4) begin
            errors++;
            $display("FAIL overflow_count got fill=%0d ovf=%0d want fill=16 ovf=4", seq_a_fill, seq_a_ovf);
        end
        checks++;
        if (txIf.TVALID !== 1'b1 || txIf.TDATA !== 8'h13) begin
            errors++;
            $display("FAIL overflow_hold got=%b/%h want=1/13", txIf.TVALID, txIf.TDATA);
        end
        // Clear together with a drop: the counter must restart at 1.
        seq_a_data = 8'h61;
        seq_a_valid = 1'b1;
        stats_clear = 1'b1;
        @(posedge clk); #1;
        seq_a_valid = 1'b0;
        stats_clear = 1'b0;
        checks++;
        if (seq_a_ovf !== 8'd1 || seq_a_fill !== 5'd16) begin
            errors++;
            $display("FAIL clear_with_drop got ovf=%0d fill=%0d want ovf=1 fill=16", seq_a_ovf, seq_a_fill);
        end
        // Push into the full FIFO on the same edge as a pop: accepted.
        txIf.TREADY = 1'b1;
        seq_a_data = 8'h60;
        seq_a_valid = 1'b1;
        exp_q.push_back(8'h60);
        @(posedge clk); #1;
        seq_a_valid = 1'b0;
        checks++;
        if (seq_a_ovf !== 8'd1 || seq_a_fill !== 5'd16) begin
            errors++;
            $display("FAIL full_push_pop got ovf=%0d fill=%0d want ovf=1 fill=16", seq_a_ovf, seq_a_fill);
        end
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_drain got=%0d left want=0", exp_q.size());
        end
        @(posedge clk); #1;
        checks++;
        if (seq_a_fill !== 5'd0 || txIf.TVALID !== 1'b0) begin
            errors++;
            $display("FAIL overflow_empty got fill=%0d valid=%b want 0/0", seq_a_fill, txIf.TVALID);
        end
    endtask

    task automatic test_priority;
        int  sw_pulses = 0;
        bit  sw_seen = 0;
        txIf.TREADY = 1'b0;
        occupy_output(8'h11, 1'b1);
        trig_in[2] = 1'b1;
        seq_a_data = 8'h21;
        seq_a_valid = 1'b1;
        seq_b_data = 8'h22;
        seq_b_valid = 1'b1;
        swIf.TDATA = 8'h40;
        swIf.TVALID = 1'b1;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h40);
        @(posedge clk); #1;
        seq_a_valid = 1'b0;
        seq_b_valid = 1'b0;
        txIf.TREADY = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (swIf.TREADY === 1'b1) begin
                sw_pulses++;
                sw_seen = 1;
            end
            @(posedge clk); #1;
            if (sw_seen && swIf.TVALID) begin
                swIf.TVALID = 1'b0;
                checks++;
                if (txIf.TVALID !== 1'b1 || txIf.TDATA !== 8'h40) begin
                    errors++;
                    $display("FAIL sw_ready_on_load got=%b/%h want=1/40", txIf.TVALID, txIf.TDATA);
                end
            end
        end
        swIf.TVALID = 1'b0;
        trig_in[2] = 1'b0;
        checks++;
        if (sw_pulses != 1) begin
            errors++;
            $display("FAIL sw_pulses got=%0d want=1", sw_pulses);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL priority_drain got=%0d left want=0", exp_q.size());
        end
    endtask

    task automatic test_coalesce;
        txIf.TREADY = 1'b0;
        occupy_output(8'h12, 1'b1);
        exp_q.push_back(8'h31);
        for (int k = 0; k < 3; k++) begin
            trig_in[0] = 1'b1;
            @(posedge clk); #1;
            trig_in[0] = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (trig_coal !== 8'd2) begin
            errors++;
            $display("FAIL coalesce_count got=%0d want=2", trig_coal);
        end
        txIf.TREADY = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || txIf.TVALID !== 1'b0) begin
            errors++;
            $display("FAIL coalesce_drain got left=%0d valid=%b want 0/0", exp_q.size(), txIf.TVALID);
        end
    endtask

    task automatic test_null;
        int sw_pulses = 0;
        int valid_seen = 0;
        txIf.TREADY = 1'b1;
        @(posedge clk); #1;
        seq_b_data = 8'h00;
        seq_b_valid = 1'b1;
        swIf.TDATA = 8'h00;
        swIf.TVALID = 1'b1;
        @(negedge clk);
        if (swIf.TREADY === 1'b1) sw_pulses++;
        @(posedge clk); #1;
        seq_b_valid = 1'b0;
        swIf.TVALID = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (swIf.TREADY === 1'b1) sw_pulses++;
            if (txIf.TVALID === 1'b1) valid_seen++;
        end
        checks++;
        if (sw_pulses != 1) begin
            errors++;
            $display("FAIL null_sw_ready got=%0d want=1", sw_pulses);
        end
        checks++;
        if (valid_seen != 0 || seq_b_fill !== 5'd0) begin
            errors++;
            $display("FAIL null_discard got valid=%0d fill=%0d want 0/0", valid_seen, seq_b_fill);
        end
    endtask

    task automatic test_reset_midstream;
        txIf.TREADY = 1'b0;
        occupy_output(8'h14, 1'b0);
        for (int i = 0; i < 4; i++) begin
            seq_a_data = 8'(8'h70 + i);
            seq_a_valid = 1'b1;
            @(posedge clk); #1;
        end
        seq_a_valid = 1'b0;
        trig_in[1] = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (txIf.TVALID !== 1'b0 || txIf.TDATA !== 8'h00 || seq_a_fill !== 5'd0 ||
            seq_a_ovf !== 8'd0 || trig_coal !== 8'd0 || dbg.pending !== 8'd0) begin
            errors++;
            $display("FAIL async_reset got valid=%b data=%h fill=%0d ovf=%0d coal=%0d pend=%h want 0",
                     txIf.TVALID, txIf.TDATA, seq_a_fill, seq_a_ovf, trig_coal, dbg.pending);
        end
        // Trigger 1 stays high through release, so exactly one 0x32 must follow.
        exp_q.push_back(8'h32);
        txIf.TREADY = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        trig_in[1] = 1'b0;
        checks++;
        if (exp_q.size() != 0 || seq_a_fill !== 5'd0) begin
            errors++;
            $display("FAIL after_reset got left=%0d fill=%0d want 0/0", exp_q.size(), seq_a_fill);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_priority();
        test_coalesce();
        test_null();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
